// File: rtl/snake_pkg.sv
// Shared definitions for the snake field bus: cell codes, directions and scanner states.
// Used by both the field writer and the scanner side.
package snake_pkg;

  localparam int CELL_W = 3;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 3'd0;
  localparam logic [CELL_W-1:0] CELL_UP    = 3'd1;
  localparam logic [CELL_W-1:0] CELL_RIGHT = 3'd2;
  localparam logic [CELL_W-1:0] CELL_DOWN  = 3'd3;
  localparam logic [CELL_W-1:0] CELL_LEFT  = 3'd4;
  localparam logic [CELL_W-1:0] CELL_APPLE = 3'd5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/snake_cell_classify.sv
// Combinational cell-code classifier: snake body (1..4), apple (5), invalid (6/7).
module snake_cell_classify
  import snake_pkg::*;
(
  input  logic [CELL_W-1:0] code,
  output logic              is_body,
  output logic              is_apple,
  output logic              is_bad
);

  assign is_body  = (code >= CELL_UP) && (code <= CELL_LEFT);
  assign is_apple = (code == CELL_APPLE);
  assign is_bad   = (code > CELL_APPLE);

endmodule

// File: rtl/snake_field_scanner.sv
// Snapshots the packed game field on request, streams it cell by cell in row-major order
// over valid/ready, and publishes per-frame snake/apple/invalid statistics.
//
// state | meaning
// IDLE  | waiting for frame_req; field snapshot taken on the accepting edge
// SCAN  | one beat per transfer, shadow register shifts right by one cell
// DONE  | single cycle, stats_valid pulse
module snake_field_scanner
  import snake_pkg::*;
#(
  parameter int unsigned SIZE_X     = 10,
  parameter int unsigned SIZE_Y     = 10,
  parameter int unsigned FIELD_SIZE = SIZE_X * SIZE_Y * CELL_W,
  parameter int unsigned XBITS      = $clog2(SIZE_X),
  parameter int unsigned YBITS      = $clog2(SIZE_Y),
  parameter int unsigned CBITS      = $clog2(SIZE_X * SIZE_Y + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_req,
  input  logic [FIELD_SIZE-1:0] field,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XBITS-1:0]      out_x,
  output logic [YBITS-1:0]      out_y,
  output logic [CELL_W-1:0]     out_cell,
  output logic                  out_first,
  output logic                  out_last,
  output logic [CBITS-1:0]      snake_len,
  output logic [CBITS-1:0]      apple_cnt,
  output logic                  bad_cell,
  output logic                  stats_valid
);

  localparam logic [XBITS-1:0] XMAX = XBITS'(SIZE_X - 1);
  localparam logic [YBITS-1:0] YMAX = YBITS'(SIZE_Y - 1);

  scan_state_e state_q, state_d;

  logic [FIELD_SIZE-1:0] shadow_q, shadow_d;
  logic [XBITS-1:0]      x_q, x_d;
  logic [YBITS-1:0]      y_q, y_d;
  logic [CBITS-1:0]      len_acc_q, len_acc_d;
  logic [CBITS-1:0]      apple_acc_q, apple_acc_d;
  logic                  bad_acc_q, bad_acc_d;
  logic [CBITS-1:0]      snake_len_q, snake_len_d;
  logic [CBITS-1:0]      apple_cnt_q, apple_cnt_d;
  logic                  bad_cell_q, bad_cell_d;

  logic is_body, is_apple, is_bad;
  logic at_xmax, at_ymax, xfer;

  snake_cell_classify u_classify (
    .code     (shadow_q[CELL_W-1:0]),
    .is_body  (is_body),
    .is_apple (is_apple),
    .is_bad   (is_bad)
  );

  assign at_xmax = (x_q == XMAX);
  assign at_ymax = (y_q == YMAX);
  assign xfer    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_req) state_d = ST_SCAN;
      ST_SCAN: if (xfer && at_xmax && at_ymax) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    out_valid   = (state_q == ST_SCAN);
    stats_valid = (state_q == ST_DONE);
  end

  always_comb begin
    shadow_d    = shadow_q;
    x_d         = x_q;
    y_d         = y_q;
    len_acc_d   = len_acc_q;
    apple_acc_d = apple_acc_q;
    bad_acc_d   = bad_acc_q;
    snake_len_d = snake_len_q;
    apple_cnt_d = apple_cnt_q;
    bad_cell_d  = bad_cell_q;
    if (state_q == ST_IDLE && frame_req) begin
      shadow_d    = field;
      x_d         = '0;
      y_d         = '0;
      len_acc_d   = '0;
      apple_acc_d = '0;
      bad_acc_d   = 1'b0;
    end else if (xfer) begin
      shadow_d    = {{CELL_W{1'b0}}, shadow_q[FIELD_SIZE-1:CELL_W]};
      x_d         = at_xmax ? '0 : x_q + XBITS'(1);
      y_d         = at_xmax ? (at_ymax ? '0 : y_q + YBITS'(1)) : y_q;
      len_acc_d   = len_acc_q + CBITS'(is_body);
      apple_acc_d = apple_acc_q + CBITS'(is_apple);
      bad_acc_d   = bad_acc_q | is_bad;
      // Published on the edge into DONE so the values are already stable during the pulse.
      if (at_xmax && at_ymax) begin
        snake_len_d = len_acc_d;
        apple_cnt_d = apple_acc_d;
        bad_cell_d  = bad_acc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      len_acc_q   <= '0;
      apple_acc_q <= '0;
      bad_acc_q   <= 1'b0;
      snake_len_q <= '0;
      apple_cnt_q <= '0;
      bad_cell_q  <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      x_q         <= x_d;
      y_q         <= y_d;
      len_acc_q   <= len_acc_d;
      apple_acc_q <= apple_acc_d;
      bad_acc_q   <= bad_acc_d;
      snake_len_q <= snake_len_d;
      apple_cnt_q <= apple_cnt_d;
      bad_cell_q  <= bad_cell_d;
    end
  end

  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_cell  = shadow_q[CELL_W-1:0];
  assign out_first = out_valid & (x_q == '0) & (y_q == '0);
  assign out_last  = out_valid & at_xmax & at_ymax;
  assign snake_len = snake_len_q;
  assign apple_cnt = apple_cnt_q;
  assign bad_cell  = bad_cell_q;

endmodule
